range_frame_sequencer: RTL
==========================

// Module: range_frame_sequencer
// PURPOSE
//  Upstream feeder for the range-finder stage. Accepts a valid/ready sample
//  stream with an end-of-frame marker and buffers it in a small FIFO. Re-times
//  each frame into the range finder's protocol: data_out, a one-cycle go on the
//  first sample, and a one-cycle finish on the last. go and finish are never
//  asserted together. Also enforces a maximum frame length.
// PARAMETERS
//  WIDTH    16  sample width; matches the range finder's data width
//  DEPTH    8   FIFO entries (power of 2, >=2)
//  MAX_LEN  64  max samples per frame (>=2); longer frames are truncated
// PORTS
//  clock         in   1                     single clock, rising edge
//  reset         in   1                     synchronous, active-high
//  in_data       in   WIDTH                 upstream sample
//  in_valid      in   1                     in_data/in_last valid
//  in_last       in   1                     sample is last of its frame
//  in_ready      out  1                     = !fifo_full; push on in_valid & in_ready
//  data_out      out  WIDTH                 sample to the range finder (registered)
//  go            out  1                     pulse: first sample of a frame
//  finish        out  1                     pulse: last sample of a frame
//  frame_len     out  $clog2(MAX_LEN+1)     sample count of the last completed frame
//  truncated     out  1                     pulse with finish when MAX_LEN cut the frame
// BEHAVIOUR
//  - Reset: FIFO empty, state IDLE. data_out=0, go=0, finish=0, frame_len=0,
//    truncated=0, in_ready=1. Reset mid-frame discards the frame silently.
//  - FIFO stores {last,data}. in_ready comes from a registered full flag, so
//    there is no push when full. Push and pop in the same cycle are legal when
//    neither full nor empty.
//  - All outputs are registered. A popped sample appears on data_out the next
//    cycle. data_out holds its value whenever nothing is popped, so gaps in a
//    frame re-present the previous sample; min/max are unaffected.
//  - cnt: frame sample counter, internal.
//  - FSM (typedef seq_state_t):
//    IDLE   : if !empty, pop. go=1, data_out=d, cnt=1.
//             If last -> SINGLE, else -> ACTIVE.
//    SINGLE : no pop. finish=1, data_out held, frame_len=1 -> IDLE.
//             This splits a one-sample frame so go and finish never overlap.
//    ACTIVE : if empty, hold; no pulses. If !empty, pop: data_out=d, cnt+1.
//             last          -> finish=1, frame_len=cnt+1, -> IDLE
//             cnt+1==MAX_LEN -> finish=1, truncated=1, frame_len=MAX_LEN, -> DRAIN
//             (if both hold, last wins: truncated=0)
//    DRAIN  : pop and discard while !empty. No pulses, data_out held.
//             Popping last -> IDLE.
//  - After finish, the next frame's go can occur on the very next cycle (IDLE pop).
//  - go/finish are mutually exclusive, and each lasts exactly one cycle.
//  - frame_len updates only in the finish cycle; it is held otherwise.
// STRUCTURE
//  - Shared package range_pkg: seq_state_t enum {IDLE, SINGLE, ACTIVE, DRAIN}.
//  - Sub-module sample_fifo #(W=WIDTH+1, DEPTH): synchronous FIFO.
//    Ports: clock, reset, push, pop, wdata, rdata (show-ahead), full, empty.
//    Pointers are one bit wider than the address, so wrap-around is detected
//    by the MSB.
//  - Top level holds the FSM, cnt, and output registers.
// TESTING
//  - Frame 3,9,5 (last on 5), in_valid continuous -> go with 3, then 9, then
//    finish with 5; frame_len=3. A downstream range finder reports 6.
//  - Single sample 7 with last -> go with data_out=7, next cycle finish with
//    data_out=7; frame_len=1; go&finish never both high.
//  - Gap: 10, (idle 3 cycles), 2, last 4 -> data_out holds 10 through the gap;
//    finish with 4; frame_len=3.
//  - MAX_LEN=4, frame of 6 samples 1..6 -> finish+truncated on sample 4;
//    samples 5,6 dropped; the next frame's go follows.
//  - Backpressure: 10 samples pushed, no gaps, DEPTH=8 -> in_ready low while
//    full; no sample lost or duplicated; order preserved.
//  - Reset asserted mid-ACTIVE -> next cycle all outputs 0, in_ready=1; the
//    following frame starts cleanly with go.

Source files
------------

// File: rtl/range_pkg.sv
// Shared types for the range-finder feeder: sequencer state encoding.
package range_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    ACTIVE = 2'd2,
    DRAIN  = 2'd3
  } seq_state_t;
endpackage

// File: rtl/range_frame_sequencer_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty flags.
module sample_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic         full_q, empty_q;
  logic         push_en, pop_en;

  assign push_en = push && !full_q;
  assign pop_en  = pop && !empty_q;
  assign wptr_d  = push_en ? wptr_q + 1'b1 : wptr_q;
  assign rptr_d  = pop_en ? rptr_q + 1'b1 : rptr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      // Same address with differing wrap bit means the write pointer lapped the read pointer.
      full_q  <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
      empty_q <= (wptr_d == rptr_d);
    end
  end

  always_ff @(posedge clock) begin
    if (push_en) mem[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr_q[AW-1:0]];
  assign full  = full_q;
  assign empty = empty_q;
endmodule

// File: rtl/range_frame_sequencer.sv
// Re-times a valid/ready sample stream into go/finish framed output for the range finder.
module range_frame_sequencer
  import range_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int MAX_LEN = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [WIDTH-1:0]               in_data,
  input  logic                           in_valid,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic [WIDTH-1:0]               data_out,
  output logic                           go,
  output logic                           finish,
  output logic [$clog2(MAX_LEN+1)-1:0]   frame_len,
  output logic                           truncated,
  output seq_state_t                     state_dbg
);
  localparam int CW = $clog2(MAX_LEN + 1);

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [WIDTH:0]   fifo_rdata;
  logic             rd_last;
  logic [WIDTH-1:0] rd_data;

  seq_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    len_q, len_d;
  logic             go_q, go_d, fin_q, fin_d, trunc_q, trunc_d;

  sample_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_valid && !fifo_full),
    .pop   (fifo_pop),
    .wdata ({in_last, in_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign rd_last  = fifo_rdata[WIDTH];
  assign rd_data  = fifo_rdata[WIDTH-1:0];
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    len_d    = len_q;
    go_d     = 1'b0;
    fin_d    = 1'b0;
    trunc_d  = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        go_d     = 1'b1;
        data_d   = rd_data;
        cnt_d    = CW'(1);
        state_d  = rd_last ? SINGLE : ACTIVE;
      end
      // A one-sample frame gets its finish a cycle after go so the pulses never overlap.
      SINGLE: begin
        fin_d   = 1'b1;
        len_d   = CW'(1);
        state_d = IDLE;
      end
      ACTIVE: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        data_d   = rd_data;
        cnt_d    = cnt_inc;
        if (rd_last) begin
          fin_d   = 1'b1;
          len_d   = cnt_inc;
          state_d = IDLE;
        end else if (cnt_inc == CW'(MAX_LEN)) begin
          fin_d   = 1'b1;
          trunc_d = 1'b1;
          len_d   = CW'(MAX_LEN);
          state_d = DRAIN;
        end
      end
      DRAIN: if (!fifo_empty) begin
        fifo_pop = 1'b1;
        if (rd_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      len_q   <= '0;
      go_q    <= 1'b0;
      fin_q   <= 1'b0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      len_q   <= len_d;
      go_q    <= go_d;
      fin_q   <= fin_d;
      trunc_q <= trunc_d;
    end
  end

  assign data_out  = data_q;
  assign go        = go_q;
  assign finish    = fin_q;
  assign frame_len = len_q;
  assign truncated = trunc_q;
  assign state_dbg = state_q;
endmodule
